// File: rtl/led_pio.sv
// Avalon-MM output PIO for the red LEDs: DATA register with atomic set/clear
// ports and an optional free-running blink engine enabled by LED_PIO_BLINK_EN.
module led_pio #(
    parameter int          WIDTH       = 18,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

    // Slave handshake: no valid/ready, no wait states; a write is accepted and
    // completed at any rising edge with chipselect=1 and write_n=0.
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_sigs;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      readdata_q, readdata_d;

    assign wr_en       = chipselect & ~write_n;
    assign wdata       = writedata[WIDTH-1:0];
    assign unused_sigs = ^{writedata, (BLINK_DIV > 1)};

`ifdef LED_PIO_BLINK_EN
    localparam int             PW         = $clog2(BLINK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(BLINK_DIV - 1);

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             phase_q, phase_d;

    always_comb begin
        mask_d  = mask_q;
        presc_d = presc_q + 1'b1;
        phase_d = phase_q;
        // Prescaler free-runs; mask writes never restart it.
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end
        if (wr_en && address == 2'd3) begin
            mask_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            presc_q <= '0;
            phase_q <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                2'd0:    data_d = wdata;
                2'd1:    data_d = data_q | wdata;
                2'd2:    data_d = data_q & ~wdata;
                default: data_d = data_q;
            endcase
        end

        readdata_d = 32'd0;
        case (address)
            2'd0:    readdata_d = 32'(data_q);
`ifdef LED_PIO_BLINK_EN
            2'd3:    readdata_d = 32'(mask_q);
`endif
            default: readdata_d = 32'd0;
        endcase

        // Output follows the committed register state one edge later, so a
        // DATA write and a phase toggle on the same edge both show together.
`ifdef LED_PIO_BLINK_EN
        out_d = data_q ^ (mask_q & {WIDTH{phase_q}});
`else
        out_d = data_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RST_V;
            out_q      <= RST_V;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;

endmodule
